// File: rtl/cgra_kernel_launcher.sv
// ---------------------------------------------------------------------------
// cgra_kernel_launcher
//
// Hardware initiator for the CGRA Computation_Start / Computation_Done
// four-phase handshake. A host request asks for N back-to-back kernel runs.
// The launcher then does the following:
//   - raises Computation_Start;
//   - waits for Computation_Done to rise, then drops Start;
//   - waits for Done to fall, then counts the run as complete;
//   - inserts GAP_CYCLES idle cycles before the next run.
// When all runs are complete, or the launch is aborted, it emits a one-cycle
// result pulse. The pulse carries the completed-run count, the elapsed cycle
// count (saturating) and an error code.
//
// Optional feature macro: TIMEOUT_EN
//   When this macro is defined, a watchdog is built in. The watchdog ends a
//   launch with Err=01 after TIMEOUT_CYCLES consecutive cycles in the
//   ASSERT or RELEASE phase.
//   When it is undefined, there is no watchdog and the launcher waits on
//   Done indefinitely.
//
// Ports
//   Clk                in   1       system clock
//   Resetn             in   1       synchronous, active-low reset
//   Launch_Valid       in   1       launch request
//   Launch_Ready       out  1       launcher can accept a request (combinational)
//   Launch_Iters       in   ITER_W  number of runs, sampled on accept
//   Abort              in   1       abort the launch in progress
//   Computation_Start  out  1       to CGRA: run kernel
//   Computation_Done   in   1       from CGRA: kernel done
//   Busy               out  1       launcher is not idle
//   Result_Valid       out  1       one-cycle result pulse
//   Result_Iters       out  ITER_W  runs fully completed
//   Result_Cycles      out  CNT_W   elapsed cycles, saturating
//   Result_Err         out  2       00 ok, 01 timeout, 10 abort
// ---------------------------------------------------------------------------
module cgra_kernel_launcher #(
    parameter int ITER_W         = 16,
    parameter int CNT_W          = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              Launch_Valid,
    output logic              Launch_Ready,
    input  logic [ITER_W-1:0] Launch_Iters,
    input  logic              Abort,
    output logic              Computation_Start,
    input  logic              Computation_Done,
    output logic              Busy,
    output logic              Result_Valid,
    output logic [ITER_W-1:0] Result_Iters,
    output logic [CNT_W-1:0]  Result_Cycles,
    output logic [1:0]        Result_Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_GAP,
        S_DRAIN,
        S_REPORT
    } state_t;

    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
    localparam logic [1:0]  ERR_ABORT   = 2'b10;

    // Last gap-counter value. This value is meaningless when GAP_CYCLES is 0,
    // because the GAP state is then never entered.
    localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [ITER_W-1:0] target_reg, target_next;
    logic [ITER_W-1:0] completed_reg, completed_next;
    logic [CNT_W-1:0]  cycles_reg, cycles_next;
    logic [31:0]       gap_reg, gap_next;
    logic [ITER_W-1:0] res_iters_reg, res_iters_next;
    logic [CNT_W-1:0]  res_cycles_reg, res_cycles_next;
    logic [1:0]        res_err_reg, res_err_next;

    logic              accept;
    logic              counting;
    logic [CNT_W-1:0]  cycles_step;
    logic [ITER_W-1:0] completed_inc;
    logic              timeout_hit;
    logic              report_now;
    logic [1:0]        report_err;
    logic [ITER_W-1:0] report_iters;
    logic [CNT_W-1:0]  report_cycles;

    // Reset is folded into Ready, so that a request presented during reset
    // can never look accepted.
    assign Launch_Ready      = (state_reg == S_IDLE) & ~Computation_Done & Resetn;
    assign accept            = Launch_Valid & Launch_Ready;
    assign Computation_Start = (state_reg == S_ASSERT);
    assign Busy              = (state_reg != S_IDLE);
    assign Result_Valid      = (state_reg == S_REPORT);
    assign Result_Iters      = res_iters_reg;
    assign Result_Cycles     = res_cycles_reg;
    assign Result_Err        = res_err_reg;

    // The elapsed-cycle count includes the current cycle when the state
    // counts. This lets a result loaded on the way into REPORT cover every
    // counted cycle up to and including the last one.
    assign counting    = (state_reg == S_ASSERT) || (state_reg == S_RELEASE) ||
                         (state_reg == S_GAP)    || (state_reg == S_DRAIN);
    assign cycles_step = (counting && !(&cycles_reg)) ? cycles_reg + 1'b1 : cycles_reg;

    // completed_reg is always strictly below target_reg while a run is
    // outstanding. The increment therefore cannot wrap, even when the target
    // is the all-ones maximum.
    assign completed_inc = completed_reg + 1'b1;

`ifdef TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wd_reg, wd_next;
    logic        wd_phase;

    assign wd_phase    = (state_reg == S_ASSERT) || (state_reg == S_RELEASE);
    assign timeout_hit = wd_phase && (wd_reg == WD_LAST);

    // The watchdog counts consecutive cycles spent in one handshake phase.
    // Any state change restarts it.
    assign wd_next = (wd_phase && (state_next == state_reg)) ? wd_reg + 32'd1 : '0;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES only matters when the watchdog is built in.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        completed_next = completed_reg;
        cycles_next    = cycles_step;
        gap_next       = gap_reg;
        report_now     = 1'b0;
        report_err     = ERR_OK;
        report_iters   = completed_reg;
        report_cycles  = cycles_step;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    target_next    = Launch_Iters;
                    completed_next = '0;
                    cycles_next    = '0;
                    gap_next       = '0;
                    if (Launch_Iters == '0) begin
                        // An empty launch reports immediately and never
                        // touches Start.
                        state_next    = S_REPORT;
                        report_now    = 1'b1;
                        report_iters  = '0;
                        report_cycles = '0;
                    end else begin
                        state_next = S_ASSERT;
                    end
                end
            end

            S_ASSERT: begin
                if (Abort) begin
                    state_next = S_DRAIN;
                end else if (timeout_hit) begin
                    state_next = S_REPORT;
                    report_now = 1'b1;
                    report_err = ERR_TIMEOUT;
                end else if (Computation_Done) begin
                    state_next = S_RELEASE;
                end
            end

            S_RELEASE: begin
                // Abort takes priority over a falling Done in the same cycle.
                // In that case the run is not counted.
                if (Abort) begin
                    state_next = S_DRAIN;
                end else if (timeout_hit) begin
                    state_next = S_REPORT;
                    report_now = 1'b1;
                    report_err = ERR_TIMEOUT;
                end else if (!Computation_Done) begin
                    completed_next = completed_inc;
                    if (completed_inc == target_reg) begin
                        state_next   = S_REPORT;
                        report_now   = 1'b1;
                        report_iters = completed_inc;
                    end else if (GAP_CYCLES == 0) begin
                        state_next = S_ASSERT;
                    end else begin
                        state_next = S_GAP;
                        gap_next   = '0;
                    end
                end
            end

            S_GAP: begin
                if (Abort) begin
                    state_next = S_DRAIN;
                end else if (gap_reg == GAP_LAST) begin
                    state_next = S_ASSERT;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + 32'd1;
                end
            end

            S_DRAIN: begin
                // Wait for the CGRA to finish its half of the handshake, so
                // that a follow-up launch starts from a clean Done=0.
                if (!Computation_Done) begin
                    state_next = S_REPORT;
                    report_now = 1'b1;
                    report_err = ERR_ABORT;
                end
            end

            S_REPORT: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The result registers are loaded on the transition into REPORT. They
    // then hold their value until the next report.
    assign res_iters_next  = report_now ? report_iters  : res_iters_reg;
    assign res_cycles_next = report_now ? report_cycles : res_cycles_reg;
    assign res_err_next    = report_now ? report_err    : res_err_reg;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_reg      <= S_IDLE;
            target_reg     <= '0;
            completed_reg  <= '0;
            cycles_reg     <= '0;
            gap_reg        <= '0;
            res_iters_reg  <= '0;
            res_cycles_reg <= '0;
            res_err_reg    <= ERR_OK;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            completed_reg  <= completed_next;
            cycles_reg     <= cycles_next;
            gap_reg        <= gap_next;
            res_iters_reg  <= res_iters_next;
            res_cycles_reg <= res_cycles_next;
            res_err_reg    <= res_err_next;
        end
    end

endmodule
